// File: rtl/alu_vector_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_vector_sequencer_pkg
//  Description : Shared ALU definitions: sequencer state encoding and the
//                width of the ALU status/display flag bus.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_vector_sequencer_pkg;

    // ALU status/display output width
    localparam int c_FLAG_W = 7;

    // Sequencer states, explicitly encoded
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LAUNCH  = 3'd1,
        WAIT    = 3'd2,
        CAPTURE = 3'd3,
        DONE    = 3'd4
    } state_t;

endpackage : alu_vector_sequencer_pkg
`default_nettype wire

// File: rtl/alu_vector_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_vector_sequencer_if
//  Description : Run control, ALU drive/return and status bundle of the
//                vector sequencer. master = sequencer side, slave = the
//                environment (ALU + controller).
//  Revision    : 1.0 - initial release
// ============================================================================
interface alu_vector_sequencer_if #(
    parameter int N = 64
);
    import alu_vector_sequencer_pkg::*;

    logic                start;
    logic                abort;
    logic [N-1:0]        alu_a;
    logic [N-1:0]        alu_b;
    logic [2:0]          alu_sel;
    logic                alu_op;
    logic                alu_valid;
    logic [N-1:0]        alu_result;
    logic [c_FLAG_W-1:0] alu_flags;
    logic                busy;
    logic                done;
    logic [7:0]          vec_index;
    logic [N-1:0]        signature;

    modport master (
        input  start, abort, alu_result, alu_flags,
        output alu_a, alu_b, alu_sel, alu_op, alu_valid,
               busy, done, vec_index, signature
    );

    modport slave (
        output start, abort, alu_result, alu_flags,
        input  alu_a, alu_b, alu_sel, alu_op, alu_valid,
               busy, done, vec_index, signature
    );

endinterface : alu_vector_sequencer_if
`default_nettype wire

// File: rtl/alu_vector_sequencer_signature_reg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_signature_reg
//  Description : N-bit rotate-left-by-one XOR accumulator. Clear wins over
//                enable; the flags are zero-extended before folding in.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_signature_reg
    import alu_vector_sequencer_pkg::*;
#(
    parameter int N      = 64,
    parameter int FLAG_W = c_FLAG_W
) (
    input  wire              clk,
    input  wire              rst,
    input  wire              i_clr,
    input  wire              i_en,
    input  wire [N-1:0]      i_result,
    input  wire [FLAG_W-1:0] i_flags,
    output logic [N-1:0]     o_sig
);

    logic [N-1:0] r_sig;

    // Accumulate: rotate the running signature and fold in result and flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sig <= '0;
        end else if (i_clr) begin
            r_sig <= '0;
        end else if (i_en) begin
            r_sig <= {r_sig[N-2:0], r_sig[N-1]} ^ i_result ^ N'(i_flags);
        end
    end

    assign o_sig = r_sig;

endmodule : alu_signature_reg
`default_nettype wire

// File: rtl/alu_vector_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : alu_vector_sequencer
//  Description : Drives NUM_VECTORS operand vectors into an external ALU,
//                waits LATENCY cycles per launch and folds every result into
//                a rotate-XOR signature. Abort cancels a run without a done.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_vector_sequencer
    import alu_vector_sequencer_pkg::*;
#(
    parameter int N           = 64,
    parameter int NUM_VECTORS = 16,
    parameter int LATENCY     = 2
) (
    input  wire                    clock,
    input  wire                    reset,
    alu_vector_sequencer_if.master bus
);

    // WAIT lasts LATENCY-1 cycles: load LATENCY-2 and count down to zero
    localparam int                 c_CNT_W     = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [c_CNT_W-1:0] c_WAIT_LOAD = c_CNT_W'((LATENCY > 1) ? (LATENCY - 2) : 0);
    localparam logic [7:0]         c_LAST_K    = 8'(NUM_VECTORS - 1);

    state_t             r_state;
    state_t             w_state_next;
    logic [7:0]         r_k;
    logic [7:0]         w_k_next;
    logic [c_CNT_W-1:0] r_wait_cnt;
    logic [c_CNT_W-1:0] w_wait_cnt_next;
    logic               w_sig_clr;
    logic               w_sig_en;
    logic [N-1:0]       r_alu_a;
    logic [N-1:0]       r_alu_b;
    logic [2:0]         r_alu_sel;
    logic               r_alu_op;

    // Next-state, vector index and signature control; abort overrides all
    always_comb begin
        w_state_next    = r_state;
        w_k_next        = r_k;
        w_wait_cnt_next = r_wait_cnt;
        w_sig_clr       = 1'b0;
        w_sig_en        = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_state_next = LAUNCH;
                    w_k_next     = 8'd0;
                    w_sig_clr    = 1'b1;
                end
            end
            LAUNCH: begin
                w_wait_cnt_next = c_WAIT_LOAD;
                w_state_next    = (LATENCY == 1) ? CAPTURE : WAIT;
            end
            WAIT: begin
                if (r_wait_cnt == '0) begin
                    w_state_next = CAPTURE;
                end else begin
                    w_wait_cnt_next = r_wait_cnt - c_CNT_W'(1);
                end
            end
            CAPTURE: begin
                w_sig_en = 1'b1;
                if (r_k == c_LAST_K) begin
                    w_state_next = DONE;
                end else begin
                    w_state_next = LAUNCH;
                    w_k_next     = r_k + 8'd1;
                end
            end
            DONE: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
        // Abort (also in IDLE together with start) freezes index and signature
        if (bus.abort) begin
            w_state_next = IDLE;
            w_k_next     = r_k;
            w_sig_clr    = 1'b0;
            w_sig_en     = 1'b0;
        end
    end

    // State, vector index and wait counter registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_k        <= 8'd0;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_state_next;
            r_k        <= w_k_next;
            r_wait_cnt <= w_wait_cnt_next;
        end
    end

    // Operands are loaded on entry to LAUNCH and held until the next launch
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_alu_a   <= '0;
            r_alu_b   <= '0;
            r_alu_sel <= 3'd0;
            r_alu_op  <= 1'b0;
        end else if (w_state_next == LAUNCH) begin
            r_alu_a   <= {N{1'b1}} - N'(w_k_next);
            r_alu_b   <= N'(w_k_next);
            r_alu_sel <= w_k_next[2:0];
            r_alu_op  <= w_k_next[3];
        end
    end

    alu_signature_reg #(
        .N      (N),
        .FLAG_W (c_FLAG_W)
    ) u_signature (
        .clk      (clock),
        .rst      (reset),
        .i_clr    (w_sig_clr),
        .i_en     (w_sig_en),
        .i_result (bus.alu_result),
        .i_flags  (bus.alu_flags),
        .o_sig    (bus.signature)
    );

    assign bus.alu_a     = r_alu_a;
    assign bus.alu_b     = r_alu_b;
    assign bus.alu_sel   = r_alu_sel;
    assign bus.alu_op    = r_alu_op;
    assign bus.alu_valid = (r_state == LAUNCH);
    assign bus.busy      = (r_state != IDLE);
    assign bus.done      = (r_state == DONE);
    assign bus.vec_index = r_k;

endmodule : alu_vector_sequencer
`default_nettype wire

// File: tb/tb_alu_vector_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_vector_sequencer
//  Description : Self-checking bench. Instance A: N=8, 4 vectors, LATENCY=1,
//                stub ALU returns alu_b. Instance B: defaults, stub ALU
//                returns alu_a with flags = alu_b[6:0]^0x2A.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_vector_sequencer;

    typedef struct packed {
        logic [63:0] a;
        logic [63:0] b;
        logic [2:0]  sel;
        logic        op;
    } drv_t;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    drv_t        q_drv_a[$];
    drv_t        q_drv_b[$];
    logic [63:0] q_sig_a[$];
    logic [63:0] q_sig_b[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    alu_vector_sequencer_if #(.N(8))  bus_a ();
    alu_vector_sequencer_if #(.N(64)) bus_b ();

    alu_vector_sequencer #(.N(8), .NUM_VECTORS(4), .LATENCY(1)) dut_a (
        .clock (clk),
        .reset (rst_a),
        .bus   (bus_a)
    );

    alu_vector_sequencer dut_b (
        .clock (clk),
        .reset (rst_b),
        .bus   (bus_b)
    );

    assign bus_a.alu_result = bus_a.alu_b;
    assign bus_a.alu_flags  = 7'd0;
    assign bus_b.alu_result = bus_b.alu_a;
    assign bus_b.alu_flags  = bus_b.alu_b[6:0] ^ 7'h2A;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic drv_t exp_drv(input int n, input int k);
        drv_t        d;
        logic [63:0] ones;
        logic [63:0] kk;
        ones  = (n == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << n) - 64'd1);
        kk    = 64'(k);
        d.a   = (ones - kk) & ones;
        d.b   = kk;
        d.sel = kk[2:0];
        d.op  = kk[3];
        return d;
    endfunction

    function automatic logic [63:0] model_sig_a(input int nvec);
        logic [7:0] sig;
        sig = 8'd0;
        for (int k = 0; k < nvec; k++) sig = {sig[6:0], sig[7]} ^ 8'(k);
        return 64'(sig);
    endfunction

    function automatic logic [63:0] model_sig_b(input int nvec);
        logic [63:0] sig;
        logic [63:0] a;
        logic [6:0]  fl;
        sig = 64'd0;
        for (int k = 0; k < nvec; k++) begin
            a   = 64'hFFFF_FFFF_FFFF_FFFF - 64'(k);
            fl  = 7'(k) ^ 7'h2A;
            sig = {sig[62:0], sig[63]} ^ a ^ {57'd0, fl};
        end
        return sig;
    endfunction

    // Scoreboard for A: launch drive, single-cycle valid, operand hold, signature
    initial begin : mon_a
        drv_t d;
        drv_t held;
        logic prev_valid;
        prev_valid = 1'b0;
        held       = '0;
        forever begin
            @(negedge clk);
            if (!rst_a) begin
                if (bus_a.alu_valid) begin
                    check_val("a_valid_width", 64'(prev_valid), 64'd0);
                    if (q_drv_a.size() == 0) begin
                        check_val("a_launch_unexpected", 64'd1, 64'd0);
                    end else begin
                        d = q_drv_a.pop_front();
                        check_val("a_alu_a", 64'(bus_a.alu_a), d.a);
                        check_val("a_alu_b", 64'(bus_a.alu_b), d.b);
                        check_val("a_sel_op", 64'({bus_a.alu_sel, bus_a.alu_op}), 64'({d.sel, d.op}));
                    end
                    held.a   = 64'(bus_a.alu_a);
                    held.b   = 64'(bus_a.alu_b);
                    held.sel = bus_a.alu_sel;
                    held.op  = bus_a.alu_op;
                end else if (bus_a.busy) begin
                    check_val("a_hold", 64'({bus_a.alu_a, bus_a.alu_b, bus_a.alu_sel, bus_a.alu_op}),
                              64'({held.a[7:0], held.b[7:0], held.sel, held.op}));
                end
                if (bus_a.done) begin
                    if (q_sig_a.size() == 0) check_val("a_done_unexpected", 64'd1, 64'd0);
                    else check_val("a_signature", 64'(bus_a.signature), q_sig_a.pop_front());
                end
            end
            prev_valid = bus_a.alu_valid;
        end
    end

    // Scoreboard for B: as for A plus launch spacing of LATENCY+1 cycles
    initial begin : mon_b
        drv_t d;
        drv_t held;
        int   last_launch;
        held        = '0;
        last_launch = -1;
        forever begin
            @(negedge clk);
            if (!rst_b) begin
                if (bus_b.alu_valid) begin
                    if (last_launch >= 0) check_val("b_launch_spacing", 64'(cyc - last_launch), 64'd3);
                    last_launch = cyc;
                    if (q_drv_b.size() == 0) begin
                        check_val("b_launch_unexpected", 64'd1, 64'd0);
                    end else begin
                        d = q_drv_b.pop_front();
                        check_val("b_alu_a", bus_b.alu_a, d.a);
                        check_val("b_alu_b", bus_b.alu_b, d.b);
                        check_val("b_sel_op", 64'({bus_b.alu_sel, bus_b.alu_op}), 64'({d.sel, d.op}));
                    end
                    held.a   = bus_b.alu_a;
                    held.b   = bus_b.alu_b;
                    held.sel = bus_b.alu_sel;
                    held.op  = bus_b.alu_op;
                end else if (bus_b.busy) begin
                    check_val("b_hold_a", bus_b.alu_a, held.a);
                    check_val("b_hold_b", bus_b.alu_b, held.b);
                end
                if (bus_b.done) begin
                    if (q_sig_b.size() == 0) check_val("b_done_unexpected", 64'd1, 64'd0);
                    else check_val("b_signature", bus_b.signature, q_sig_b.pop_front());
                end
            end
            if (!bus_b.busy) last_launch = -1;
        end
    end

    task automatic wait_done_a(input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus_a.done) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) check_val("a_done_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_done_b(input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus_b.done) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) check_val("b_done_timeout", 64'd0, 64'd1);
    endtask

    task automatic run_a();
        int t0;
        int at;
        for (int k = 0; k < 4; k++) q_drv_a.push_back(exp_drv(8, k));
        q_sig_a.push_back(model_sig_a(4));
        bus_a.start = 1'b1;
        @(negedge clk);
        check_val("a_accept_busy", 64'(bus_a.busy), 64'd1);
        t0 = cyc;
        bus_a.start = 1'b0;
        wait_done_a(20, at);
        check_val("a_done_latency", 64'(at - t0), 64'd8);
        @(negedge clk);
        check_val("a_idle_after_done", 64'(bus_a.busy), 64'd0);
        check_val("a_sig_golden", 64'(bus_a.signature), 64'h03);
        check_val("a_vec_index_hold", 64'(bus_a.vec_index), 64'd3);
    endtask

    task automatic run_b(input logic mid_start);
        int t0;
        int at;
        for (int k = 0; k < 16; k++) q_drv_b.push_back(exp_drv(64, k));
        q_sig_b.push_back(model_sig_b(16));
        bus_b.start = 1'b1;
        @(negedge clk);
        check_val("b_accept_busy", 64'(bus_b.busy), 64'd1);
        t0 = cyc;
        bus_b.start = 1'b0;
        if (mid_start) begin
            repeat (10) @(negedge clk);
            bus_b.start = 1'b1;
            @(negedge clk);
            bus_b.start = 1'b0;
        end
        wait_done_b(100, at);
        check_val("b_done_latency", 64'(at - t0), 64'd48);
        @(negedge clk);
        check_val("b_idle_after_done", 64'(bus_b.busy), 64'd0);
        check_val("b_sig_held", bus_b.signature, model_sig_b(16));
    endtask

    initial begin : main
        logic [63:0] sig_before;
        logic        found;
        bus_a.start = 1'b0;
        bus_a.abort = 1'b0;
        bus_b.start = 1'b0;
        bus_b.abort = 1'b0;
        rst_a = 1'b1;
        rst_b = 1'b1;
        repeat (2) @(negedge clk);

        // Reset state
        check_val("a_rst_busy", 64'(bus_a.busy), 64'd0);
        check_val("a_rst_done", 64'(bus_a.done), 64'd0);
        check_val("a_rst_valid", 64'(bus_a.alu_valid), 64'd0);
        check_val("a_rst_operands", 64'({bus_a.alu_a, bus_a.alu_b, bus_a.alu_sel, bus_a.alu_op}), 64'd0);
        check_val("a_rst_vec_index", 64'(bus_a.vec_index), 64'd0);
        check_val("a_rst_signature", 64'(bus_a.signature), 64'd0);
        check_val("b_rst_busy", 64'(bus_b.busy), 64'd0);
        check_val("b_rst_signature", bus_b.signature, 64'd0);
        rst_a = 1'b0;
        rst_b = 1'b0;
        repeat (2) @(negedge clk);

        // Small configuration: 8-cycle run, golden signature 0x03
        run_a();

        // Start and abort together in IDLE: no run, signature untouched
        bus_a.start = 1'b1;
        bus_a.abort = 1'b1;
        @(negedge clk);
        check_val("a_sa_busy1", 64'(bus_a.busy), 64'd0);
        @(negedge clk);
        check_val("a_sa_busy2", 64'(bus_a.busy), 64'd0);
        check_val("a_sa_sig", 64'(bus_a.signature), 64'h03);
        bus_a.start = 1'b0;
        bus_a.abort = 1'b0;
        @(negedge clk);

        // Default configuration with a start pulse in the middle of the run
        run_b(1'b1);

        // Abort during WAIT of vector 5
        for (int k = 0; k < 6; k++) q_drv_b.push_back(exp_drv(64, k));
        bus_b.start = 1'b1;
        @(negedge clk);
        bus_b.start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus_b.alu_valid && bus_b.vec_index == 8'd5) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check_val("b_reach_k5", 64'(found), 64'd1);
        @(negedge clk);
        check_val("b_in_wait", 64'({bus_b.busy, bus_b.alu_valid, bus_b.done}), 64'b100);
        sig_before = bus_b.signature;
        check_val("b_sig_before_abort", sig_before, model_sig_b(5));
        bus_b.abort = 1'b1;
        @(negedge clk);
        bus_b.abort = 1'b0;
        check_val("b_abort_busy", 64'(bus_b.busy), 64'd0);
        check_val("b_abort_done", 64'(bus_b.done), 64'd0);
        check_val("b_abort_vec_index", 64'(bus_b.vec_index), 64'd5);
        check_val("b_abort_sig", bus_b.signature, sig_before);
        repeat (3) @(negedge clk);
        check_val("b_abort_stays_idle", 64'(bus_b.busy), 64'd0);

        // Asynchronous reset in the middle of a run
        for (int k = 0; k < 16; k++) q_drv_b.push_back(exp_drv(64, k));
        q_sig_b.push_back(model_sig_b(16));
        bus_b.start = 1'b1;
        @(negedge clk);
        bus_b.start = 1'b0;
        repeat (20) @(negedge clk);
        #2;
        rst_b = 1'b1;
        #1;
        check_val("b_arst_busy_done_valid", 64'({bus_b.busy, bus_b.done, bus_b.alu_valid}), 64'd0);
        check_val("b_arst_alu_a", bus_b.alu_a, 64'd0);
        check_val("b_arst_alu_b", bus_b.alu_b, 64'd0);
        check_val("b_arst_sel_op", 64'({bus_b.alu_sel, bus_b.alu_op}), 64'd0);
        check_val("b_arst_vec_index", 64'(bus_b.vec_index), 64'd0);
        check_val("b_arst_signature", bus_b.signature, 64'd0);
        q_drv_b.delete();
        q_sig_b.delete();
        @(negedge clk);
        rst_b = 1'b0;
        repeat (3) @(negedge clk);
        check_val("b_post_rst_idle", 64'(bus_b.busy), 64'd0);

        // Fresh run after reset reproduces the golden signature
        run_b(1'b0);

        repeat (2) @(negedge clk);
        check_val("a_queues_empty", 64'(q_drv_a.size() + q_sig_a.size()), 64'd0);
        check_val("b_queues_empty", 64'(q_drv_b.size() + q_sig_b.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_alu_vector_sequencer
`default_nettype wire

// File: doc/alu_vector_sequencer.md
ALU_VECTOR_SEQUENCER -- requirements
Module: alu_vector_sequencer

Interface
REQ-001 Parameters SHALL be, one per line:
- N, 64, operand/result width.
- NUM_VECTORS, 16, vectors per run (2..256).
- LATENCY, 2, cycles from launch to result valid (>=1).
REQ-002 Ports SHALL be, one per line:
- clock  in  1  single clock, all state updates on rising edge.
- reset  in  1  asynchronous, active-high.
- start  in  1  run request, sampled in IDLE only.
- abort  in  1  synchronous run cancel.
- alu_a  out  N  operand A to ALU.
- alu_b  out  N  operand B to ALU.
- alu_sel  out  3  ALU selector.
- alu_op  out  1  ALU operation bit.
- alu_valid  out  1  one-cycle launch strobe.
- alu_result  in  N  ALU result.
- alu_flags  in  7  ALU 7-bit status/display output.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle end-of-run pulse.
- vec_index  out  8  index of the current vector.
- signature  out  N  accumulated result signature.

Function
REQ-003 FSM states SHALL be IDLE, LAUNCH, WAIT, CAPTURE, DONE.
REQ-004 IDLE->LAUNCH SHALL occur on start=1; k is cleared and signature zeroed in the same edge.
REQ-005 For vector k: alu_a SHALL be {N{1'b1}} minus k, alu_b SHALL be k zero-extended, alu_sel SHALL be k[2:0], and alu_op SHALL be k[3].
REQ-006 alu_a, alu_b, alu_sel and alu_op SHALL be registered and held stable from LAUNCH through CAPTURE of each vector.
REQ-007 alu_valid SHALL be 1 only in LAUNCH.
REQ-008 WAIT SHALL last LATENCY-1 cycles and SHALL be skipped when LATENCY=1.
REQ-009 In CAPTURE, signature SHALL update to {sig[N-2:0],sig[N-1]} ^ alu_result ^ zero-extended alu_flags.
REQ-010 CAPTURE SHALL go to LAUNCH with k+1 if k<NUM_VECTORS-1, otherwise to DONE.
REQ-011 Each vector SHALL take LATENCY+1 cycles; DONE SHALL be entered NUM_VECTORS*(LATENCY+1) cycles after start is accepted.
REQ-012 DONE SHALL assert done for exactly one cycle, then return to IDLE; signature SHALL be held until the next accepted start.
REQ-013 start SHALL be ignored while busy=1.
REQ-014 abort=1 in any non-IDLE state SHALL go to IDLE next cycle with no done pulse and signature frozen; abort SHALL take priority over every other transition, including CAPTURE->DONE.
REQ-015 start and abort both high in IDLE: abort SHALL win and the run SHALL not start.
REQ-016 vec_index SHALL equal k while busy and SHALL hold its last value in IDLE.

Reset
REQ-017 Reset SHALL force IDLE, alu_a=alu_b=0, alu_sel=0, alu_op=0, alu_valid=0, busy=0, done=0, vec_index=0, signature=0, immediately and independent of clock.
REQ-018 Reset asserted mid-run SHALL discard the run; after release the block SHALL wait in IDLE for start.

Structure
REQ-019 The state enum and the flag-width constant (7) SHALL live in the shared ALU package.
REQ-020 The signature register SHALL be a sub-module alu_signature_reg (N-bit rotate-XOR accumulator with clear/enable).
REQ-021 The block SHALL instantiate no ALU; the ALU and the operand/result registers sit outside it.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- N=8, NUM_VECTORS=4, LATENCY=1, stub ALU returning alu_b with flags 0; pulse start -> done after 8 cycles, signature=0x03.
- Same stub, check the drive for k=2 -> alu_a=0xFD, alu_b=0x02, alu_sel=2, alu_op=0, alu_valid high for 1 cycle per vector.
- Defaults with stub result=alu_a: alu_valid pulses spaced 3 cycles apart -> done 48 cycles after start accepted; start pulsed mid-run has no effect.
- abort during WAIT of k=5 -> IDLE next cycle, no done, vec_index=5, signature unchanged.
- reset asserted asynchronously mid-run -> all outputs 0 before the next edge; a new start then gives the golden signature.
- start and abort high together in IDLE -> busy stays 0.
